apb_req_scheduler: RTL

- Front-end scheduler that shares one APB master bridge among NUM_REQ independent requesters.
- Each requester has a one-entry request slot. A true round-robin arbiter picks one pending slot at a time.
- The winner's command is driven onto the bridge's per-channel read/write command interface and held until completion. The response (read data, error) is then returned to the owning requester.
- A watchdog ends transfers that never complete.

---
 rtl/apb_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 25 ++
 rtl/apb_req_scheduler.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/apb_sched_pkg.sv
// rtl/apb_sched_pkg.sv - shared state type, default widths and round-robin search for apb_req_scheduler
package apb_sched_pkg;
   localparam int DEF_DATA_WIDTH     = 32;
   localparam int DEF_ADDR_WIDTH     = 32;
   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_TIMEOUT_CYCLES = 256;
   localparam int MAX_REQ            = 32;
   localparam int MAX_IW             = 5;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

   // First set bit at or after ptr, wrapping within n; -1 when nothing is set.
   // Walking k downwards lets the closest index overwrite farther ones.
   function automatic int rr_next(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
      logic [MAX_IW-1:0] idx;
      rr_next = -1;
      for (int k = n - 1; k >= 0; k--) begin
         idx = MAX_IW'((ptr + k) % n);
         if (req[idx]) rr_next = int'(idx);
      end
   endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick over pending slots; pointer lives in the parent
module rr_arbiter
   import apb_sched_pkg::*;
#(
   parameter int N = 4,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);
   logic [MAX_REQ-1:0] req_ext;
   int                 win;

   always_comb begin
      req_ext        = '0;
      req_ext[N-1:0] = req;
      win            = rr_next(req_ext, int'(ptr), N);
      any            = (win >= 0);
      grant_idx      = any ? IW'(win) : '0;
      grant          = any ? (N'(1) << grant_idx) : '0;
   end
endmodule

// File: rtl/apb_req_scheduler.sv
// rtl/apb_req_scheduler.sv - shares one APB bridge among NUM_REQ one-entry request slots
// with round-robin arbitration, response routing and a per-transfer watchdog.
module apb_req_scheduler
   import apb_sched_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic                           PCLK,
   input  logic                           PRESET,
   input  logic [NUM_REQ-1:0]             req_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   input  logic [NUM_REQ-1:0]             req_write,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
   output logic [NUM_REQ-1:0]             resp_valid,
   output logic [DATA_WIDTH-1:0]          resp_rdata,
   output logic                           resp_err,
   output logic [NUM_REQ-1:0]             br_read,
   output logic [NUM_REQ-1:0]             br_write,
   output logic [ADDR_WIDTH-1:0]          br_address,
   output logic [DATA_WIDTH-1:0]          br_write_data,
   input  logic [DATA_WIDTH-1:0]          br_read_data,
   input  logic [NUM_REQ-1:0]             br_access_complete,
   input  logic [NUM_REQ-1:0]             br_invalid_access,
   output logic [NUM_REQ-1:0]             timeout_sticky,
   output logic                           busy
);
   localparam int IW = $clog2(NUM_REQ);

   state_e                state_q;
   logic [NUM_REQ-1:0]    occ_q, slot_wr_q;
   logic [ADDR_WIDTH-1:0] slot_addr_q  [NUM_REQ];
   logic [DATA_WIDTH-1:0] slot_wdata_q [NUM_REQ];
   logic [IW-1:0]         ptr_q, ptr_d, g_q;
   logic [TO_W-1:0]       cnt_q;
   logic [NUM_REQ-1:0]    resp_valid_q, br_read_q, br_write_q, sticky_q;
   logic                  resp_err_q;
   logic [DATA_WIDTH-1:0] rdata_q, br_wdata_q;
   logic [ADDR_WIDTH-1:0] br_addr_q;

   logic [NUM_REQ-1:0]    grant;
   logic [IW-1:0]         grant_idx;
   logic                  any;
   logic                  done, timed_out;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req       (occ_q),
      .ptr       (ptr_q),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any)
   );

   assign ptr_d     = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
   assign done      = br_access_complete[g_q];
   assign timed_out = (cnt_q == TO_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q      <= IDLE;
         occ_q        <= '0;
         slot_wr_q    <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_addr_q[i]  <= '0;
            slot_wdata_q[i] <= '0;
         end
         ptr_q        <= '0;
         g_q          <= '0;
         cnt_q        <= '0;
         resp_valid_q <= '0;
         resp_err_q   <= 1'b0;
         rdata_q      <= '0;
         br_read_q    <= '0;
         br_write_q   <= '0;
         br_addr_q    <= '0;
         br_wdata_q   <= '0;
         sticky_q     <= '0;
      end else begin
         // Slots only load while empty, so a granted slot is frozen until its RESP.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && !occ_q[i]) begin
               occ_q[i]        <= 1'b1;
               slot_wr_q[i]    <= req_write[i];
               slot_addr_q[i]  <= req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
               slot_wdata_q[i] <= req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
         end
         resp_valid_q <= '0;
         case (state_q)
            IDLE: begin
               if (any) begin
                  g_q        <= grant_idx;
                  ptr_q      <= ptr_d;
                  cnt_q      <= '0;
                  br_read_q  <= slot_wr_q[grant_idx] ? '0 : grant;
                  br_write_q <= slot_wr_q[grant_idx] ? grant : '0;
                  br_addr_q  <= slot_addr_q[grant_idx];
                  br_wdata_q <= slot_wdata_q[grant_idx];
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               cnt_q <= cnt_q + TO_W'(1);
               if (done) begin
                  if (br_read_q[g_q]) rdata_q <= br_read_data;
                  resp_err_q <= br_invalid_access[g_q];
               end else if (timed_out) begin
                  resp_err_q    <= 1'b1;
                  sticky_q[g_q] <= 1'b1;
               end
               if (done || timed_out) begin
                  br_read_q    <= '0;
                  br_write_q   <= '0;
                  resp_valid_q <= NUM_REQ'(1) << g_q;
                  state_q      <= RESP;
               end
            end
            RESP: begin
               occ_q[g_q] <= 1'b0;
               resp_err_q <= 1'b0;
               state_q    <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign req_ready      = ~occ_q;
   assign resp_valid     = resp_valid_q;
   assign resp_rdata     = rdata_q;
   assign resp_err       = resp_err_q;
   assign br_read        = br_read_q;
   assign br_write       = br_write_q;
   assign br_address     = br_addr_q;
   assign br_write_data  = br_wdata_q;
   assign timeout_sticky = sticky_q;
   assign busy           = (state_q != IDLE);
endmodule
